// File: rtl/mips_bus_initiator.sv
`default_nettype none
// ============================================================================
// mips_bus_initiator : single-outstanding load/store initiator for the MIPS
// core's word-addressed memory bus (lane steering, waits, load extension).
// Revision: 1.0
// ============================================================================
module mips_bus_initiator (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUS    = 3'd1,
    S_RDWAIT = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t      r_state, w_state_nx;
  logic        r_is_write, w_is_write_nx;
  logic [1:0]  r_size, w_size_nx;
  logic        r_signed, w_signed_nx;
  logic [1:0]  r_lane, w_lane_nx;

  logic        w_read_nx, w_write_nx, w_resp_valid_nx, w_resp_error_nx;
  logic [31:0] w_address_nx, w_writedata_nx, w_resp_rdata_nx;
  logic [3:0]  w_byteenable_nx;

  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign req_ready = (r_state == S_IDLE) && reset;

  // Request decode: alignment check, byte enables and lane replication.
  always_comb begin
    w_bad = 1'b0;
    w_be  = 4'b0000;
    w_wd  = req_wdata;
    case (req_size)
      2'b00: begin
        w_be = 4'b0001 << req_addr[1:0];
        w_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_bad = req_addr[0];
        w_be  = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wd  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_bad = |req_addr[1:0];
        w_be  = 4'b1111;
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = readdata[7:0];
      2'd1:    w_byte = readdata[15:8];
      2'd2:    w_byte = readdata[23:16];
      default: w_byte = readdata[31:24];
    endcase
    w_half = r_lane[1] ? readdata[31:16] : readdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = readdata;
    endcase
  end

  always_comb begin
    w_state_nx      = r_state;
    w_is_write_nx   = r_is_write;
    w_size_nx       = r_size;
    w_signed_nx     = r_signed;
    w_lane_nx       = r_lane;
    w_read_nx       = read;
    w_write_nx      = write;
    w_address_nx    = address;
    w_byteenable_nx = byteenable;
    w_writedata_nx  = writedata;
    w_resp_valid_nx = 1'b0;
    w_resp_error_nx = 1'b0;
    w_resp_rdata_nx = resp_rdata;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_is_write_nx = req_write;
          w_size_nx     = req_size;
          w_signed_nx   = req_signed;
          w_lane_nx     = req_addr[1:0];
          if (w_bad) begin
            w_state_nx      = S_ERR;
            w_resp_valid_nx = 1'b1;
            w_resp_error_nx = 1'b1;
            w_resp_rdata_nx = 32'd0;
          end else begin
            w_state_nx      = S_BUS;
            w_read_nx       = ~req_write;
            w_write_nx      = req_write;
            w_address_nx    = {req_addr[31:2], 2'b00};
            w_byteenable_nx = w_be;
            w_writedata_nx  = w_wd;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          w_read_nx  = 1'b0;
          w_write_nx = 1'b0;
          if (r_is_write) begin
            w_state_nx      = S_RESP;
            w_resp_valid_nx = 1'b1;
            w_resp_rdata_nx = 32'd0;
          end else begin
            w_state_nx = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        w_state_nx      = S_RESP;
        w_resp_valid_nx = 1'b1;
        w_resp_rdata_nx = w_load;
      end
      default: begin
        w_state_nx      = S_IDLE;
        w_resp_rdata_nx = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_lane     <= 2'b00;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 32'd0;
      byteenable <= 4'b0000;
      writedata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      r_state    <= w_state_nx;
      r_is_write <= w_is_write_nx;
      r_size     <= w_size_nx;
      r_signed   <= w_signed_nx;
      r_lane     <= w_lane_nx;
      read       <= w_read_nx;
      write      <= w_write_nx;
      address    <= w_address_nx;
      byteenable <= w_byteenable_nx;
      writedata  <= w_writedata_nx;
      resp_valid <= w_resp_valid_nx;
      resp_error <= w_resp_error_nx;
      resp_rdata <= w_resp_rdata_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_initiator.sv
`default_nettype none
// ============================================================================
// tb_mips_bus_initiator : directed + randomized checks against a byte-level
// reference model of the load/store bus initiator.
// Revision: 1.0
// ============================================================================
module tb_mips_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata, address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_rdata;

  mips_bus_initiator dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an access of 2^size bytes starting at byte address addr.
  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int v;
    v = ((1 << (1 << size)) - 1) << addr[1:0];
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    int n;
    n = 1 << size;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = wdata[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int n, lo;
    n  = 1 << size;
    lo = int'(addr[1:0]);
    v  = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(lo+i) +: 8];
    if (sgn && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic scramble_req();
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One transaction with a fixed cycle schedule; garbage is driven on every
  // input the initiator must ignore in each cycle.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int waits);
    logic        err, bus_on;
    int          n_wait, resp_at;
    logic [31:0] exp_rdata;
    err       = model_err(size, addr);
    n_wait    = err ? 0 : waits;
    resp_at   = err ? 1 : (wr ? n_wait + 2 : n_wait + 3);
    exp_rdata = (wr || err) ? 32'd0 : model_load(size, sgn, addr, rd);

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_size    = size;
    req_signed  = sgn;
    req_addr    = addr;
    req_wdata   = wdata;
    readdata    = $urandom;
    waitrequest = 1'($urandom);
    @(posedge clk);
    #1;
    for (int k = 1; k <= resp_at + 1; k++) begin
      if (k <= resp_at) begin
        req_valid = 1'($urandom);
        scramble_req();
      end else begin
        req_valid = 1'b0;
      end
      if (k <= n_wait)           waitrequest = 1'b1;
      else if (k == n_wait + 1)  waitrequest = 1'b0;
      else                       waitrequest = 1'($urandom);
      readdata = (!wr && !err && k == n_wait + 2) ? rd : $urandom;
      @(negedge clk);
      bus_on = !err && (k <= n_wait + 1);
      check("read", 32'(read), 32'(bus_on && !wr));
      check("write", 32'(write), 32'(bus_on && wr));
      if (bus_on) begin
        check("address", address, {addr[31:2], 2'b00});
        check("byteenable", 32'(byteenable), 32'(model_be(size, addr)));
        if (wr) check("writedata", writedata, model_wd(size, wdata));
      end
      check("req_ready", 32'(req_ready), 32'(k == resp_at + 1));
      check("resp_valid", 32'(resp_valid), 32'(k == resp_at));
      if (k == resp_at) begin
        check("resp_error", 32'(resp_error), 32'(err));
        check("resp_rdata", resp_rdata, exp_rdata);
        last_rdata = resp_rdata;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_mid_bus();
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_size    = 2'b10;
    req_addr    = 32'h0000_0040;
    waitrequest = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_read", 32'(read), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_async_read", 32'(read), 32'd0);
    check("rst_async_address", address, 32'd0);
    check("rst_async_be", 32'(byteenable), 32'd0);
    check("rst_ready_low", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_resp", 32'(resp_valid), 32'd0);
      check("rst_no_read", 32'(read), 32'd0);
    end
    reset       = 1'b1;
    waitrequest = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    readdata = 32'd0;
    waitrequest = 1'b0;
    last_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_read", 32'(read), 32'd0);
    check("reset_write", 32'(write), 32'd0);
    check("reset_address", address, 32'd0);
    check("reset_be", 32'(byteenable), 32'd0);
    check("reset_wdata", writedata, 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_error", 32'(resp_error), 32'd0);
    check("reset_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'd0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'd0, 32'h8001_7F00, 0);
    check("tp_half_signed", last_rdata, 32'hFFFF_8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'd0, 32'h8001_7F00, 0);
    check("tp_half_unsigned", last_rdata, 32'h0000_8001);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'd0, 32'h0000_8000, 3);
    check("tp_byte_signed", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0, 32'h1234_5678, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'd0, 32'h1234_5678, 0);
    do_req(1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'h1111_2222, 32'd0, 0);

    reset_mid_bus();
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'd0, 32'hCAFE_F00D, 1);
    check("post_reset_load", last_rdata, 32'hCAFE_F00D);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b11)
        a = a & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
